// File: rtl/wb_ram_arbiter.sv
// -----------------------------------------------------------------------------
// wb_ram_arbiter
// Two-master Wishbone B3 arbiter in front of a single RAM-style slave port.
// Ownership is granted per bus cycle (cyc envelope) and held until the owner
// drops cyc, so bursts are never split. Ties alternate between the masters.
// A watchdog aborts an owner whose strobe stays unterminated for `timeout`
// consecutive cycles, answering it with err and freeing the slave.
//
// Ports:
//   wb_clk_i, wb_rst_i          clock, asynchronous active-high reset
//   m0_*_i / m1_*_i             master requests (adr, bte, cti, cyc, stb, we,
//                               sel, dat)
//   m0_*_o / m1_*_o             master responses (dat, ack, err, rty)
//   s_*_o                       slave request, muxed from the current owner
//   s_dat_i, s_ack_i, s_err_i,
//   s_rty_i                     slave response
// -----------------------------------------------------------------------------
module wb_ram_arbiter #(
   parameter int dw      = 32,
   parameter int aw      = 25,
   parameter int timeout = 255
) (
   input  logic          wb_clk_i,
   input  logic          wb_rst_i,
   // master 0
   input  logic [aw-1:0] m0_adr_i,
   input  logic [1:0]    m0_bte_i,
   input  logic [2:0]    m0_cti_i,
   input  logic          m0_cyc_i,
   input  logic          m0_stb_i,
   input  logic          m0_we_i,
   input  logic [3:0]    m0_sel_i,
   input  logic [dw-1:0] m0_dat_i,
   output logic [dw-1:0] m0_dat_o,
   output logic          m0_ack_o,
   output logic          m0_err_o,
   output logic          m0_rty_o,
   // master 1
   input  logic [aw-1:0] m1_adr_i,
   input  logic [1:0]    m1_bte_i,
   input  logic [2:0]    m1_cti_i,
   input  logic          m1_cyc_i,
   input  logic          m1_stb_i,
   input  logic          m1_we_i,
   input  logic [3:0]    m1_sel_i,
   input  logic [dw-1:0] m1_dat_i,
   output logic [dw-1:0] m1_dat_o,
   output logic          m1_ack_o,
   output logic          m1_err_o,
   output logic          m1_rty_o,
   // slave
   output logic [aw-1:0] s_adr_o,
   output logic [1:0]    s_bte_o,
   output logic [2:0]    s_cti_o,
   output logic          s_cyc_o,
   output logic          s_stb_o,
   output logic          s_we_o,
   output logic [3:0]    s_sel_o,
   output logic [dw-1:0] s_dat_o,
   input  logic [dw-1:0] s_dat_i,
   input  logic          s_ack_i,
   input  logic          s_err_i,
   input  logic          s_rty_i
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_BUSY  = 2'd1,
      S_ABORT = 2'd2
   } state_t;

   // A zero timeout disables the watchdog; the limit wraps harmlessly then.
   localparam bit       WD_EN    = (timeout != 0);
   localparam bit [7:0] WD_LIMIT = 8'(timeout - 1);

   state_t      r_state;
   state_t      w_state_next;
   logic        r_owner;
   logic        w_owner_next;
   logic        r_last;
   logic        w_last_next;
   logic [7:0]  r_wd_cnt;
   logic [7:0]  w_wd_next;

   logic        w_own_cyc;
   logic        w_own_stb;
   logic        w_term;
   logic        w_grant;
   logic        w_s_cyc;
   logic        w_s_stb;
   logic [1:0]  w_ack;
   logic [1:0]  w_err;
   logic [1:0]  w_rty;

   // Request fields always follow the owner; cyc/stb gating makes them inert
   // whenever no one owns the slave.
   assign s_adr_o   = r_owner ? m1_adr_i : m0_adr_i;
   assign s_bte_o   = r_owner ? m1_bte_i : m0_bte_i;
   assign s_cti_o   = r_owner ? m1_cti_i : m0_cti_i;
   assign s_we_o    = r_owner ? m1_we_i  : m0_we_i;
   assign s_sel_o   = r_owner ? m1_sel_i : m0_sel_i;
   assign s_dat_o   = r_owner ? m1_dat_i : m0_dat_i;
   assign s_cyc_o   = w_s_cyc;
   assign s_stb_o   = w_s_stb;

   assign m0_dat_o  = s_dat_i;
   assign m1_dat_o  = s_dat_i;
   assign m0_ack_o  = w_ack[0];
   assign m1_ack_o  = w_ack[1];
   assign m0_err_o  = w_err[0];
   assign m1_err_o  = w_err[1];
   assign m0_rty_o  = w_rty[0];
   assign m1_rty_o  = w_rty[1];

   assign w_own_cyc = r_owner ? m1_cyc_i : m0_cyc_i;
   assign w_own_stb = r_owner ? m1_stb_i : m0_stb_i;
   assign w_term    = s_ack_i | s_err_i | s_rty_i;
   // On a tie the master that did not win last time is chosen.
   assign w_grant   = (m0_cyc_i & m1_cyc_i) ? ~r_last : m1_cyc_i;

   always_comb begin
      w_state_next = r_state;
      w_owner_next = r_owner;
      w_last_next  = r_last;
      w_wd_next    = r_wd_cnt;
      w_s_cyc      = 1'b0;
      w_s_stb      = 1'b0;
      w_ack        = 2'b00;
      w_err        = 2'b00;
      w_rty        = 2'b00;
      case (r_state)
         S_IDLE: begin
            if (m0_cyc_i | m1_cyc_i) begin
               w_state_next = S_BUSY;
               w_owner_next = w_grant;
               w_last_next  = w_grant;
               w_wd_next    = 8'd0;
            end
         end
         S_BUSY: begin
            w_s_cyc        = w_own_cyc;
            w_s_stb        = w_own_stb;
            w_ack[r_owner] = s_ack_i;
            w_err[r_owner] = s_err_i;
            w_rty[r_owner] = s_rty_i;
            if (!w_own_cyc) begin
               w_state_next = S_IDLE;
               w_wd_next    = 8'd0;
            end else if (w_term || !w_own_stb) begin
               // a termination in the limit cycle beats the watchdog
               w_wd_next = 8'd0;
            end else if (WD_EN && (r_wd_cnt == WD_LIMIT)) begin
               w_state_next = S_ABORT;
               w_wd_next    = 8'd0;
            end else begin
               w_wd_next = r_wd_cnt + 8'd1;
            end
         end
         S_ABORT: begin
            // slave is released; the stuck owner gets err for each strobe
            w_err[r_owner] = w_own_stb;
            if (!w_own_cyc) begin
               w_state_next = S_IDLE;
            end
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         r_state  <= S_IDLE;
         r_owner  <= 1'b0;
         r_last   <= 1'b1;     // m0 wins the first tie
         r_wd_cnt <= 8'd0;
      end else begin
         r_state  <= w_state_next;
         r_owner  <= w_owner_next;
         r_last   <= w_last_next;
         r_wd_cnt <= w_wd_next;
      end
   end

endmodule

// File: tb/tb_wb_ram_arbiter.sv
module tb_wb_ram_arbiter;
   localparam int DW = 32;
   localparam int AW = 25;
   localparam int T  = 8;

   logic          wb_clk_i = 1'b0;
   logic          wb_rst_i;
   logic [AW-1:0] m0_adr_i, m1_adr_i;
   logic [1:0]    m0_bte_i, m1_bte_i;
   logic [2:0]    m0_cti_i, m1_cti_i;
   logic          m0_cyc_i, m1_cyc_i, m0_stb_i, m1_stb_i, m0_we_i, m1_we_i;
   logic [3:0]    m0_sel_i, m1_sel_i;
   logic [DW-1:0] m0_dat_i, m1_dat_i;
   logic [DW-1:0] s_dat_i;
   logic          s_ack_i, s_err_i, s_rty_i;

   // outputs of the timeout=8 instance
   logic [DW-1:0] m0_dat_o, m1_dat_o, s_dat_o;
   logic          m0_ack_o, m0_err_o, m0_rty_o, m1_ack_o, m1_err_o, m1_rty_o;
   logic [AW-1:0] s_adr_o;
   logic [1:0]    s_bte_o;
   logic [2:0]    s_cti_o;
   logic          s_cyc_o, s_stb_o, s_we_o;
   logic [3:0]    s_sel_o;

   // outputs of the timeout=0 instance
   logic [DW-1:0] z_m0_dat_o, z_m1_dat_o, z_s_dat_o;
   logic          z_m0_ack_o, z_m0_err_o, z_m0_rty_o, z_m1_ack_o, z_m1_err_o, z_m1_rty_o;
   logic [AW-1:0] z_s_adr_o;
   logic [1:0]    z_s_bte_o;
   logic [2:0]    z_s_cti_o;
   logic          z_s_cyc_o, z_s_stb_o, z_s_we_o;
   logic [3:0]    z_s_sel_o;

   int tests = 0;
   int fails = 0;

   always #5 wb_clk_i = ~wb_clk_i;

   wb_ram_arbiter #(.dw(DW), .aw(AW), .timeout(T)) u_dut (
      .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
      .m0_adr_i(m0_adr_i), .m0_bte_i(m0_bte_i), .m0_cti_i(m0_cti_i), .m0_cyc_i(m0_cyc_i),
      .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i), .m0_sel_i(m0_sel_i), .m0_dat_i(m0_dat_i),
      .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o), .m0_rty_o(m0_rty_o),
      .m1_adr_i(m1_adr_i), .m1_bte_i(m1_bte_i), .m1_cti_i(m1_cti_i), .m1_cyc_i(m1_cyc_i),
      .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i), .m1_sel_i(m1_sel_i), .m1_dat_i(m1_dat_i),
      .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o), .m1_rty_o(m1_rty_o),
      .s_adr_o(s_adr_o), .s_bte_o(s_bte_o), .s_cti_o(s_cti_o), .s_cyc_o(s_cyc_o),
      .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_sel_o(s_sel_o), .s_dat_o(s_dat_o),
      .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_rty_i(s_rty_i)
   );

   wb_ram_arbiter #(.dw(DW), .aw(AW), .timeout(0)) u_dut0 (
      .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
      .m0_adr_i(m0_adr_i), .m0_bte_i(m0_bte_i), .m0_cti_i(m0_cti_i), .m0_cyc_i(m0_cyc_i),
      .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i), .m0_sel_i(m0_sel_i), .m0_dat_i(m0_dat_i),
      .m0_dat_o(z_m0_dat_o), .m0_ack_o(z_m0_ack_o), .m0_err_o(z_m0_err_o), .m0_rty_o(z_m0_rty_o),
      .m1_adr_i(m1_adr_i), .m1_bte_i(m1_bte_i), .m1_cti_i(m1_cti_i), .m1_cyc_i(m1_cyc_i),
      .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i), .m1_sel_i(m1_sel_i), .m1_dat_i(m1_dat_i),
      .m1_dat_o(z_m1_dat_o), .m1_ack_o(z_m1_ack_o), .m1_err_o(z_m1_err_o), .m1_rty_o(z_m1_rty_o),
      .s_adr_o(z_s_adr_o), .s_bte_o(z_s_bte_o), .s_cti_o(z_s_cti_o), .s_cyc_o(z_s_cyc_o),
      .s_stb_o(z_s_stb_o), .s_we_o(z_s_we_o), .s_sel_o(z_s_sel_o), .s_dat_o(z_s_dat_o),
      .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_rty_i(s_rty_i)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got %b, expected %b", name, act, exp);
      end
   endtask

   task automatic idle_inputs();
      m0_adr_i = 25'h100;  m1_adr_i = 25'h200;
      m0_bte_i = 2'b00;    m1_bte_i = 2'b00;
      m0_cti_i = 3'b000;   m1_cti_i = 3'b000;
      m0_cyc_i = 1'b0;     m1_cyc_i = 1'b0;
      m0_stb_i = 1'b0;     m1_stb_i = 1'b0;
      m0_we_i  = 1'b0;     m1_we_i  = 1'b1;
      m0_sel_i = 4'hF;     m1_sel_i = 4'h3;
      m0_dat_i = 32'h0A0A0A0A; m1_dat_i = 32'h1B1B1B1B;
      s_dat_i  = 32'hDEADBEEF;
      s_ack_i  = 1'b0; s_err_i = 1'b0; s_rty_i = 1'b0;
   endtask

   // Leaves the bench at a falling edge with both DUTs idle.
   task automatic do_reset();
      wb_rst_i = 1'b1;
      idle_inputs();
      repeat (2) @(posedge wb_clk_i);
      @(negedge wb_clk_i);
      wb_rst_i = 1'b0;
   endtask

   typedef struct packed {
      logic [3:0] req;    // {m0_cyc, m0_stb, m1_cyc, m1_stb}
      logic [2:0] term;   // {s_ack, s_err, s_rty}
      logic       e_cyc;
      logic       e_stb;
      logic       e_own;  // which master's address must reach the slave
      logic [2:0] e_t0;   // {m0_ack, m0_err, m0_rty}
      logic [2:0] e_t1;   // {m1_ack, m1_err, m1_rty}
   } vec_t;

   vec_t vecs [19];

   // behavioural reference state for the random phase
   int   holder;     // -1 when nobody holds the slave
   int   prev_win;
   bit   aborted;
   int   stall;
   bit   rc [2];
   bit   rs [2];

   initial begin
      logic [2:0]    e_t0, e_t1, tv;
      logic          e_cyc, e_stb;
      logic [AW-1:0] e_adr;
      logic [2:0]    e_cti;

      // ---------------- asynchronous reset, no clock needed ----------------
      idle_inputs();
      m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
      s_ack_i = 1'b1; s_err_i = 1'b1; s_rty_i = 1'b1;
      wb_rst_i = 1'b1;
      #1;
      chk1("rst s_cyc", s_cyc_o, 1'b0);
      chk1("rst s_stb", s_stb_o, 1'b0);
      chk("rst m0 terms", 32'({m0_ack_o, m0_err_o, m0_rty_o}), 32'd0);
      chk("rst m1 terms", 32'({m1_ack_o, m1_err_o, m1_rty_o}), 32'd0);
      $display("[TB] reset: s_cyc=%b s_stb=%b terms=%b%b%b/%b%b%b", s_cyc_o, s_stb_o,
               m0_ack_o, m0_err_o, m0_rty_o, m1_ack_o, m1_err_o, m1_rty_o);

      // ---------------- table-driven arbitration sequence ----------------
      vecs[0]  = '{4'b1111, 3'b000, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000}; // tie from reset
      vecs[1]  = '{4'b1111, 3'b000, 1'b1, 1'b1, 1'b0, 3'b000, 3'b000}; // m0 granted
      vecs[2]  = '{4'b1111, 3'b100, 1'b1, 1'b1, 1'b0, 3'b100, 3'b000}; // m0 acked
      vecs[3]  = '{4'b0011, 3'b000, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000}; // m0 drops cyc
      vecs[4]  = '{4'b0011, 3'b100, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000}; // dead cycle
      vecs[5]  = '{4'b1111, 3'b000, 1'b1, 1'b1, 1'b1, 3'b000, 3'b000}; // m1 owns
      vecs[6]  = '{4'b1111, 3'b100, 1'b1, 1'b1, 1'b1, 3'b000, 3'b100};
      vecs[7]  = '{4'b1100, 3'b000, 1'b0, 1'b0, 1'b1, 3'b000, 3'b000}; // m1 drops
      vecs[8]  = '{4'b1111, 3'b000, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000}; // tie again
      vecs[9]  = '{4'b1111, 3'b010, 1'b1, 1'b1, 1'b0, 3'b010, 3'b000}; // m0 wins, err
      vecs[10] = '{4'b1111, 3'b001, 1'b1, 1'b1, 1'b0, 3'b001, 3'b000}; // rty
      vecs[11] = '{4'b0000, 3'b000, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000};
      vecs[12] = '{4'b0011, 3'b000, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000}; // m1 alone
      vecs[13] = '{4'b0011, 3'b000, 1'b1, 1'b1, 1'b1, 3'b000, 3'b000};
      vecs[14] = '{4'b0000, 3'b000, 1'b0, 1'b0, 1'b1, 3'b000, 3'b000}; // one-cycle gap
      vecs[15] = '{4'b0011, 3'b000, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000};
      vecs[16] = '{4'b0011, 3'b100, 1'b1, 1'b1, 1'b1, 3'b000, 3'b100}; // m1 regranted
      vecs[17] = '{4'b0010, 3'b000, 1'b1, 1'b0, 1'b1, 3'b000, 3'b000}; // cyc w/o stb
      vecs[18] = '{4'b0000, 3'b000, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000};

      do_reset();
      for (int i = 0; i < 19; i++) begin
         {m0_cyc_i, m0_stb_i, m1_cyc_i, m1_stb_i} = vecs[i].req;
         {s_ack_i, s_err_i, s_rty_i} = vecs[i].term;
         s_dat_i = (i == 2) ? 32'hDEADBEEF : $urandom;
         #1;
         chk1($sformatf("vec%0d s_cyc", i), s_cyc_o, vecs[i].e_cyc);
         chk1($sformatf("vec%0d s_stb", i), s_stb_o, vecs[i].e_stb);
         chk($sformatf("vec%0d m0 terms", i), 32'({m0_ack_o, m0_err_o, m0_rty_o}), 32'(vecs[i].e_t0));
         chk($sformatf("vec%0d m1 terms", i), 32'({m1_ack_o, m1_err_o, m1_rty_o}), 32'(vecs[i].e_t1));
         chk($sformatf("vec%0d m0_dat", i), m0_dat_o, s_dat_i);
         chk($sformatf("vec%0d m1_dat", i), m1_dat_o, s_dat_i);
         if (vecs[i].e_cyc)
            chk($sformatf("vec%0d s_adr", i), 32'(s_adr_o), vecs[i].e_own ? 32'h200 : 32'h100);
         $display("[TB] vec %0d req=%b term=%b -> s_cyc=%b s_stb=%b adr=%0h t0=%b%b%b t1=%b%b%b",
                  i, vecs[i].req, vecs[i].term, s_cyc_o, s_stb_o, s_adr_o,
                  m0_ack_o, m0_err_o, m0_rty_o, m1_ack_o, m1_err_o, m1_rty_o);
         @(negedge wb_clk_i);
      end

      // ---------------- m1 wrap burst, m0 requesting mid-burst ----------------
      do_reset();
      m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_cti_i = 3'b010; m1_bte_i = 2'b01; m1_adr_i = 25'h40;
      #1 chk1("burst idle s_cyc", s_cyc_o, 1'b0);
      @(negedge wb_clk_i);
      for (int b = 0; b < 4; b++) begin
         e_cti = (b == 3) ? 3'b111 : 3'b010;
         e_adr = 25'h40 + 25'(4 * b);
         m1_cti_i = e_cti; m1_adr_i = e_adr;
         s_ack_i = 1'b1; s_dat_i = 32'h1000 + 32'(b);
         m0_cyc_i = (b >= 1); m0_stb_i = (b >= 1);
         #1;
         chk1($sformatf("burst%0d s_cyc", b), s_cyc_o, 1'b1);
         chk($sformatf("burst%0d s_adr", b), 32'(s_adr_o), 32'(e_adr));
         chk($sformatf("burst%0d s_cti", b), 32'(s_cti_o), 32'(e_cti));
         chk($sformatf("burst%0d s_bte", b), 32'(s_bte_o), 32'd1);
         chk1($sformatf("burst%0d m1_ack", b), m1_ack_o, 1'b1);
         chk1($sformatf("burst%0d m0_ack", b), m0_ack_o, 1'b0);
         $display("[TB] burst beat %0d adr=%0h cti=%b m1_ack=%b m0_ack=%b", b, s_adr_o, s_cti_o, m1_ack_o, m0_ack_o);
         @(negedge wb_clk_i);
      end
      m1_cyc_i = 1'b0; m1_stb_i = 1'b0; s_ack_i = 1'b0;
      #1 chk1("burst end s_cyc", s_cyc_o, 1'b0);
      @(negedge wb_clk_i);
      #1 chk1("burst dead s_cyc", s_cyc_o, 1'b0);
      @(negedge wb_clk_i);
      #1 chk1("burst handover s_cyc", s_cyc_o, 1'b1);
      chk("burst handover s_adr", 32'(s_adr_o), 32'h100);
      $display("[TB] burst handover: s_cyc=%b adr=%0h", s_cyc_o, s_adr_o);
      @(negedge wb_clk_i);

      // ---------------- watchdog with timeout=8 ----------------
      do_reset();
      m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
      @(negedge wb_clk_i);
      for (int i = 0; i < T; i++) begin
         if (i == 2) begin m1_cyc_i = 1'b1; m1_stb_i = 1'b1; end
         #1;
         chk1($sformatf("wd stall%0d s_stb", i), s_stb_o, 1'b1);
         chk1($sformatf("wd stall%0d m0_err", i), m0_err_o, 1'b0);
         @(negedge wb_clk_i);
      end
      for (int i = 0; i < 3; i++) begin
         #1;
         chk1($sformatf("wd abort%0d s_stb", i), s_stb_o, 1'b0);
         chk1($sformatf("wd abort%0d s_cyc", i), s_cyc_o, 1'b0);
         chk1($sformatf("wd abort%0d m0_err", i), m0_err_o, 1'b1);
         chk1($sformatf("wd abort%0d m1_err", i), m1_err_o, 1'b0);
         @(negedge wb_clk_i);
      end
      m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
      #1 chk1("wd release m0_err", m0_err_o, 1'b0);
      @(negedge wb_clk_i);
      #1 chk1("wd idle s_cyc", s_cyc_o, 1'b0);
      @(negedge wb_clk_i);
      #1 chk1("wd m1 grant s_cyc", s_cyc_o, 1'b1);
      chk("wd m1 grant s_adr", 32'(s_adr_o), 32'h200);
      $display("[TB] watchdog: aborted m0, then m1 granted adr=%0h", s_adr_o);

      // ack in the limit cycle wins, and the count restarts
      do_reset();
      m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
      @(negedge wb_clk_i);
      repeat (T - 1) @(negedge wb_clk_i);
      s_ack_i = 1'b1;
      #1 chk1("wd limit ack", m0_ack_o, 1'b1);
      @(negedge wb_clk_i);
      s_ack_i = 1'b0;
      repeat (T - 1) @(negedge wb_clk_i);
      #1 chk1("wd restart last stb", s_stb_o, 1'b1);
      chk1("wd restart no err", m0_err_o, 1'b0);
      @(negedge wb_clk_i);
      #1 chk1("wd restart fires", m0_err_o, 1'b1);
      $display("[TB] watchdog: limit-cycle ack kept BUSY, count restarted");

      // ---------------- timeout=0: long stall then ack ----------------
      do_reset();
      m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
      @(negedge wb_clk_i);
      for (int i = 1; i <= 300; i++) begin
         #1 chk1($sformatf("t0 stall%0d err", i), z_m0_err_o, 1'b0);
         @(negedge wb_clk_i);
      end
      s_ack_i = 1'b1;
      #1;
      chk1("t0 cycle301 ack", z_m0_ack_o, 1'b1);
      chk1("t0 cycle301 stb", z_s_stb_o, 1'b1);
      $display("[TB] timeout0: ack=%b err=%b on stb cycle 301", z_m0_ack_o, z_m0_err_o);

      // ---------------- reset pulse mid-burst ----------------
      do_reset();
      m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_cti_i = 3'b010;
      @(negedge wb_clk_i);
      s_ack_i = 1'b1;
      #1 chk1("rstmid pre m0_ack", m0_ack_o, 1'b1);
      #2 wb_rst_i = 1'b1;
      #1;
      chk1("rstmid s_cyc", s_cyc_o, 1'b0);
      chk1("rstmid s_stb", s_stb_o, 1'b0);
      chk("rstmid terms", 32'({m0_ack_o, m0_err_o, m0_rty_o, m1_ack_o, m1_err_o, m1_rty_o}), 32'd0);
      m1_cyc_i = 1'b1; m1_stb_i = 1'b1; s_ack_i = 1'b0;
      @(negedge wb_clk_i);
      wb_rst_i = 1'b0;
      #1 chk1("rstmid idle s_cyc", s_cyc_o, 1'b0);
      @(negedge wb_clk_i);
      #1 chk1("rstmid tie s_cyc", s_cyc_o, 1'b1);
      chk("rstmid tie s_adr", 32'(s_adr_o), 32'h100);
      $display("[TB] reset mid-burst: tie after reset -> adr=%0h", s_adr_o);

      // ---------------- random traffic against reference model ----------------
      do_reset();
      holder = -1; prev_win = 1; aborted = 1'b0; stall = 0;
      for (int i = 0; i < 1500; i++) begin
         m0_cyc_i = m0_cyc_i ? ($urandom_range(5) != 0) : ($urandom_range(2) == 0);
         m1_cyc_i = m1_cyc_i ? ($urandom_range(5) != 0) : ($urandom_range(2) == 0);
         m0_stb_i = m0_cyc_i && ($urandom_range(3) != 0);
         m1_stb_i = m1_cyc_i && ($urandom_range(3) != 0);
         m0_adr_i = 25'($urandom); m1_adr_i = 25'($urandom);
         m0_dat_i = $urandom;      m1_dat_i = $urandom;
         m0_sel_i = 4'($urandom);  m1_sel_i = 4'($urandom);
         m0_we_i  = 1'($urandom);  m1_we_i  = 1'($urandom);
         m0_cti_i = 3'($urandom);  m1_cti_i = 3'($urandom);
         m0_bte_i = 2'($urandom);  m1_bte_i = 2'($urandom);
         s_dat_i  = $urandom;
         tv = 3'b000;
         if (((i / 40) % 3) != 2) begin
            case ($urandom_range(15))
               0, 1, 2, 3, 4: tv = 3'b100;
               5:             tv = 3'b010;
               6:             tv = 3'b001;
               default:       tv = 3'b000;
            endcase
         end
         {s_ack_i, s_err_i, s_rty_i} = tv;
         rc[0] = m0_cyc_i; rc[1] = m1_cyc_i;
         rs[0] = m0_stb_i; rs[1] = m1_stb_i;

         e_cyc = 1'b0; e_stb = 1'b0; e_t0 = 3'b000; e_t1 = 3'b000;
         if (holder >= 0) begin
            if (!aborted) begin
               e_cyc = rc[holder];
               e_stb = rs[holder];
               if (holder == 0) e_t0 = tv; else e_t1 = tv;
            end else begin
               if (holder == 0) e_t0 = {1'b0, rs[0], 1'b0};
               else             e_t1 = {1'b0, rs[1], 1'b0};
            end
         end
         #1;
         chk1($sformatf("rnd%0d s_cyc", i), s_cyc_o, e_cyc);
         chk1($sformatf("rnd%0d s_stb", i), s_stb_o, e_stb);
         chk($sformatf("rnd%0d m0 terms", i), 32'({m0_ack_o, m0_err_o, m0_rty_o}), 32'(e_t0));
         chk($sformatf("rnd%0d m1 terms", i), 32'({m1_ack_o, m1_err_o, m1_rty_o}), 32'(e_t1));
         chk($sformatf("rnd%0d m0_dat", i), m0_dat_o, s_dat_i);
         chk($sformatf("rnd%0d m1_dat", i), m1_dat_o, s_dat_i);
         if (e_cyc) begin
            chk($sformatf("rnd%0d s_adr", i), 32'(s_adr_o), 32'(holder == 1 ? m1_adr_i : m0_adr_i));
            chk($sformatf("rnd%0d s_dat", i), s_dat_o, holder == 1 ? m1_dat_i : m0_dat_i);
            chk($sformatf("rnd%0d s_ctl", i), 32'({s_we_o, s_sel_o, s_cti_o, s_bte_o}),
                holder == 1 ? 32'({m1_we_i, m1_sel_i, m1_cti_i, m1_bte_i})
                            : 32'({m0_we_i, m0_sel_i, m0_cti_i, m0_bte_i}));
         end

         @(posedge wb_clk_i);
         if (holder < 0) begin
            if (rc[0] || rc[1]) begin
               holder   = (rc[0] && rc[1]) ? (1 - prev_win) : (rc[0] ? 0 : 1);
               prev_win = holder;
               aborted  = 1'b0;
               stall    = 0;
               $display("[TB] rnd cycle %0d: grant m%0d (req m0=%b m1=%b)", i, holder, rc[0], rc[1]);
            end
         end else if (!rc[holder]) begin
            holder = -1;
         end else if (!aborted) begin
            if (tv != 3'b000 || !rs[holder]) begin
               stall = 0;
            end else begin
               stall++;
               if (stall == T) begin
                  aborted = 1'b1;
                  $display("[TB] rnd cycle %0d: watchdog abort of m%0d", i, holder);
               end
            end
         end
         @(negedge wb_clk_i);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
